// File: rtl/pool_axis_tx.sv
// pool_axis_tx: AXI4-Stream transmitter for the second pooling stage.
// Each Cal_Valid strobe delivers one pooled word; words are buffered in a
// FIFO_DEPTH-entry FIFO plus one output register and sent out with full
// TVALID/TREADY backpressure.
// Optional feature macro: POOL_AXIS_TX_TLAST_EN builds the frame beat counter,
// TLAST and Frame_Done. Without it both outputs are tied low.
//
// state | meaning
// EMPTY | output register holds nothing, TVALID=0
// HOLD  | output register holds a beat, TVALID=1
module pool_axis_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int FRAME_LEN  = 169
) (
    input  logic                  M_AXIS_ACLK,
    input  logic                  M_AXIS_ARESET,
    input  logic                  Cal_Valid,
    input  logic [DATA_WIDTH-1:0] Cal_Data,
    output logic                  Tx_Full,
    output logic                  Tx_Overflow,
    output logic                  M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,
    output logic                  Frame_Done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {S_EMPTY = 1'b0, S_HOLD = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count_q, count_d;
    logic                  fire, wr_en, pop, push, bypass;

    assign M_AXIS_TVALID = (state_q == S_HOLD);
    assign fire          = M_AXIS_TVALID & M_AXIS_TREADY;
    // Tx_Full mirrors count==FIFO_DEPTH, so a strobe while full is always
    // dropped, even when a pop frees a slot in the same cycle.
    assign wr_en         = Cal_Valid & ~Tx_Full;

    // State register
    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) state_q <= S_EMPTY;
        else               state_q <= state_d;
    end

    // Next state and refill decision: FIFO head first, then bypass, else drain
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        bypass  = 1'b0;
        if (state_q == S_EMPTY || fire) begin
            if (count_q != '0) begin
                pop     = 1'b1;
                state_d = S_HOLD;
            end else if (wr_en) begin
                bypass  = 1'b1;
                state_d = S_HOLD;
            end else begin
                state_d = S_EMPTY;
            end
        end
        push = wr_en & ~bypass;
    end

    // Occupancy after this edge; simultaneous push and pop cancel
    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    // FIFO pointers, occupancy, registered full flag and sticky overflow
    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            Tx_Full     <= 1'b0;
            Tx_Overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_d;
            Tx_Full <= (count_d == CW'(FIFO_DEPTH));
            if (Cal_Valid && Tx_Full) Tx_Overflow <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge M_AXIS_ACLK) begin
        if (push) mem[wr_ptr] <= Cal_Data;
    end

    // Output data register; held stable while a beat waits for TREADY
    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET)  M_AXIS_TDATA <= '0;
        else if (pop)       M_AXIS_TDATA <= mem[rd_ptr];
        else if (bypass)    M_AXIS_TDATA <= Cal_Data;
    end

`ifdef POOL_AXIS_TX_TLAST_EN
    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(FRAME_LEN - 1);

    logic [BW-1:0] beat_q;

    assign M_AXIS_TLAST = M_AXIS_TVALID & (beat_q == BEAT_LAST);

    // Beat counter advances per transferred beat; Frame_Done trails the last beat
    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            beat_q     <= '0;
            Frame_Done <= 1'b0;
        end else begin
            Frame_Done <= fire & M_AXIS_TLAST;
            if (fire) beat_q <= (beat_q == BEAT_LAST) ? '0 : beat_q + BW'(1);
        end
    end
`else
    assign M_AXIS_TLAST = 1'b0;
    assign Frame_Done   = 1'b0;
`endif

endmodule

// File: tb/tb_pool_axis_tx.sv
module tb_pool_axis_tx;
    localparam int DW = 16;
    localparam int FL = 4;
`ifdef POOL_AXIS_TX_TLAST_EN
    localparam bit TLAST_EN = 1'b1;
`else
    localparam bit TLAST_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cal_valid = 1'b0;
    logic [DW-1:0] cal_data = '0;
    logic          tx_full, tx_overflow, tvalid, tlast, frame_done;
    logic [DW-1:0] tdata;
    logic          tready = 1'b1;

    int            total = 0;
    int            passed = 0;
    logic [DW-1:0] exp_q[$];
    int            beat_m = 0;
    logic          fd_pend = 1'b0;
    int            tlast_seen = 0;
    int            fd_seen = 0;

    pool_axis_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .FRAME_LEN(FL)) dut (
        .M_AXIS_ACLK   (clk),
        .M_AXIS_ARESET (rst),
        .Cal_Valid     (cal_valid),
        .Cal_Data      (cal_data),
        .Tx_Full       (tx_full),
        .Tx_Overflow   (tx_overflow),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TLAST  (tlast),
        .M_AXIS_TREADY (tready),
        .Frame_Done    (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [DW-1:0] d, input bit accept);
        cal_valid = 1'b1;
        cal_data  = d;
        if (accept) exp_q.push_back(d);
        tick();
        cal_valid = 1'b0;
    endtask

    task automatic do_reset();
        cal_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !tvalid) break;
            tick();
        end
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_tvalid"}, tvalid, 1'b0);
    endtask

    // Scoreboard: every presented beat must match the queue head, pop on transfer
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            beat_m  = 0;
            fd_pend = 1'b0;
        end else begin
            check("frame_done", frame_done, fd_pend);
            if (frame_done) fd_seen++;
            fd_pend = 1'b0;
            if (tvalid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_tvalid", tvalid, 1'b0);
                end else begin
                    check("tdata", tdata, exp_q[0]);
                    check("tlast", tlast, TLAST_EN && (beat_m == FL - 1));
                    if (tready) begin
                        void'(exp_q.pop_front());
                        if (tlast) tlast_seen++;
                        fd_pend = TLAST_EN && (beat_m == FL - 1);
                        beat_m  = (beat_m == FL - 1) ? 0 : beat_m + 1;
                    end
                end
            end else begin
                check("tlast_idle", tlast, 1'b0);
            end
        end
    end

    initial begin
        tick();
        tick();
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tdata", tdata, 16'h0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_full", tx_full, 1'b0);
        check("rst_ovf", tx_overflow, 1'b0);
        check("rst_fdone", frame_done, 1'b0);
        rst = 1'b0;

        // Back-to-back strobes with an always-ready sink
        tready = 1'b1;
        tick();
        strobe(16'h0001, 1'b1);
        check("lat_tvalid", tvalid, 1'b1);
        check("t1_full", tx_full, 1'b0);
        strobe(16'h0002, 1'b1);
        check("t1_full", tx_full, 1'b0);
        strobe(16'h0003, 1'b1);
        check("t1_full", tx_full, 1'b0);
        drain("t1");

        // Fill to capacity, then overflow
        do_reset();
        tready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            strobe(DW'(16'h10 + i), 1'b1);
            if (i == 7) check("t2_full_at8", tx_full, 1'b0);
        end
        check("t2_full_at9", tx_full, 1'b1);
        check("t2_ovf_pre", tx_overflow, 1'b0);
        strobe(16'h0019, 1'b0);
        check("t2_ovf", tx_overflow, 1'b1);
        tready = 1'b1;
        drain("t2");
        check("t2_ovf_sticky", tx_overflow, 1'b1);

        // Two frames of FL beats
        do_reset();
        tlast_seen = 0;
        fd_seen = 0;
        for (int i = 0; i < 8; i++) strobe(DW'(16'h100 + i), 1'b1);
        drain("t3");
        tick();
        check("t3_tlasts", tlast_seen, TLAST_EN ? 2 : 0);
        check("t3_fdones", fd_seen, TLAST_EN ? 2 : 0);

        // Toggling TREADY during a burst
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tready = i[0] ? 1'b0 : 1'b1;
            strobe(DW'(16'h30 + i), 1'b1);
        end
        for (int i = 0; i < 20; i++) begin
            tready = ~tready;
            tick();
        end
        tready = 1'b1;
        drain("t4");

        // Full FIFO with pop and strobe in the same cycle
        do_reset();
        tready = 1'b0;
        for (int i = 0; i < 9; i++) strobe(DW'(16'h20 + i), 1'b1);
        check("t5_full", tx_full, 1'b1);
        tready = 1'b1;
        strobe(16'h0029, 1'b0);
        tready = 1'b0;
        check("t5_ovf", tx_overflow, 1'b1);
        check("t5_full_after_pop", tx_full, 1'b0);
        strobe(16'h002A, 1'b1);
        check("t5_full_refill", tx_full, 1'b1);
        tready = 1'b1;
        drain("t5");

        // Asynchronous reset mid-frame
        do_reset();
        tready = 1'b1;
        strobe(16'h0040, 1'b1);
        strobe(16'h0041, 1'b1);
        strobe(16'h0042, 1'b1);
        tready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t6_tvalid", tvalid, 1'b0);
        check("t6_tdata", tdata, 16'h0);
        check("t6_tlast", tlast, 1'b0);
        check("t6_full", tx_full, 1'b0);
        check("t6_ovf", tx_overflow, 1'b0);
        check("t6_fdone", frame_done, 1'b0);
        tick();
        rst = 1'b0;
        tready = 1'b1;
        tlast_seen = 0;
        for (int i = 0; i < 4; i++) strobe(DW'(16'h50 + i), 1'b1);
        drain("t6");
        check("t6_tlasts", tlast_seen, TLAST_EN ? 1 : 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end
endmodule

// File: doc/pool_axis_tx.md
# pool_axis_tx

AXI4-Stream transmitter on the output side of the second pooling stage. Accepts one pooled result per `Cal_Valid` strobe from the pooling FSM/timer datapath and buffers it in a small FIFO. Drives results out as an AXI4-Stream master with full TVALID/TREADY backpressure and a TLAST marker at each frame boundary. It is the sending counterpart of the S_AXIS input side feeding the pooling core.

## Interface
- `DATA_WIDTH`, 16, width of result word and TDATA
- `FIFO_DEPTH`, 8, FIFO entries, power of two, ≥2 (output register is extra)
- `FRAME_LEN`, 169, beats per frame (13×13 pooled map), ≥1
- `M_AXIS_ACLK`  in  1  clock; all logic rising-edge
- `M_AXIS_ARESET`  in  1  reset, asynchronous, active-high
- `Cal_Valid`  in  1  one-cycle strobe: `Cal_Data` valid this cycle
- `Cal_Data`  in  DATA_WIDTH  pooled result word
- `Tx_Full`  out  1  FIFO holds FIFO_DEPTH entries; producer must not strobe
- `Tx_Overflow`  out  1  sticky: a strobe was dropped
- `M_AXIS_TVALID`  out  1  output register holds a beat
- `M_AXIS_TDATA`  out  DATA_WIDTH  beat data
- `M_AXIS_TLAST`  out  1  current beat is last of frame
- `M_AXIS_TREADY`  in  1  sink accepts beat
- `Frame_Done`  out  1  one-cycle pulse after last beat of a frame transfers

## Operation
- Storage: FIFO (wr_ptr, rd_ptr, count 0..FIFO_DEPTH) plus one output register. The FSM is two states: EMPTY (TVALID=0) and HOLD (TVALID=1).
- Handshake `fire` = TVALID & TREADY.
- Write: `Cal_Valid` & !Tx_Full → word enters the pipeline.
  - Bypass: if FIFO is empty and output register is free (EMPTY, or HOLD with fire), word loads directly into output register.
  - Otherwise word is pushed into the FIFO.
- `Cal_Valid` & Tx_Full → word dropped, Tx_Overflow←1. Dropped even if a pop occurs the same cycle.
- Output register refill: in EMPTY, or in HOLD with fire, load FIFO head if count>0 (pop); else apply bypass; else go to EMPTY.
- HOLD with !TREADY: TDATA/TLAST/TVALID held stable (AXI rule). No pop occurs.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Beat counter 0..FRAME_LEN-1 advances only on fire and wraps to 0 after FRAME_LEN-1.
- TLAST = TVALID & (beat counter == FRAME_LEN-1).
- Frame_Done pulses the cycle after a fire with TLAST=1.
- Word order out equals strobe order; no reordering, no duplication.

## Timing
- Reset values: TVALID=0, TDATA=0, TLAST=0, Tx_Full=0, Tx_Overflow=0, Frame_Done=0; pointers, count and beat counter 0; state EMPTY.
- Reset mid-frame discards FIFO and output register contents and restarts the frame at beat 0.
- Latency: strobe in cycle N with pipeline empty → TVALID=1 in cycle N+1.
- Sustained throughput with TREADY=1: one beat per cycle, no bubbles, FIFO stays empty.
- Tx_Full is registered and reflects count after the current edge. A producer sampling it in cycle N must not strobe in N.
- Maximum buffering: FIFO_DEPTH+1 words (FIFO plus output register).
- FRAME_LEN=1: TLAST=1 on every beat; Frame_Done pulses after each beat.

## Configuration
- `POOL_AXIS_TX_TLAST_EN` defined: beat counter, TLAST and Frame_Done behave as above.
- Undefined: beat counter is not built; M_AXIS_TLAST and Frame_Done are tied 0; FRAME_LEN is ignored. All other behaviour is identical.

## Test plan
- Reset, TREADY=1, strobe 0x0001..0x0003 on consecutive cycles → TVALID cycles 1–3 carry 0x0001,0x0002,0x0003; Tx_Full stays 0.
- TREADY=0, strobe 9 words 0x10..0x18 → output reg=0x10, FIFO full after 9th word, Tx_Full=1. 10th strobe 0x19 → Tx_Overflow=1. TREADY=1 → 0x10..0x18 emerge in order; 0x19 never appears.
- FRAME_LEN=4, 8 strobes, TREADY=1 → TLAST on beats 4 and 8 only; Frame_Done pulses one cycle after each.
- TREADY toggling 1,0,1,0 during a 6-word burst → TDATA/TLAST stable while TREADY=0; all 6 words delivered once, in order.
- Full FIFO with a pop and a strobe in the same cycle → strobe dropped, Tx_Overflow=1, count drops to 7.
- Assert M_AXIS_ARESET at beat 2 of a FRAME_LEN=4 frame → all outputs 0 immediately. After release, 4 new strobes give TLAST on the 4th beat.
